// File: rtl/solver_pkg.sv
// rtl/solver_pkg.sv - shared encodings and header layout for the solver job dispatcher
package solver_pkg;

    localparam int TAG_BITS     = 8;
    localparam int ITER_BITS    = 16;
    localparam int HDR_TAG_LSB  = 0;
    localparam int HDR_ITER_LSB = 8;
    localparam int HDR_NL_LSB   = 24;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_LD_RE,
        ST_LD_IM,
        ST_ARM,
        ST_RUN,
        ST_DONE
    } state_e;

    // A zero iteration limit would leave the solver with nothing to do; run it once instead.
    function automatic logic [ITER_BITS-1:0] coerce_iter(input logic [ITER_BITS-1:0] v);
        return (v == '0) ? ITER_BITS'(1) : v;
    endfunction

endpackage

// File: rtl/solver_result_buf.sv
// rtl/solver_result_buf.sv - one-entry valid/ready holding register for a tagged solver result
module solver_result_buf
    import solver_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_valid_i,
    output logic                 load_ready_o,
    input  logic [TAG_BITS-1:0]  load_tag_i,
    input  logic [ITER_BITS-1:0] load_count_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [TAG_BITS-1:0]  res_tag_o,
    output logic [ITER_BITS-1:0] res_count_o
);

    logic                 valid_q, valid_d;
    logic [TAG_BITS-1:0]  tag_q, tag_d;
    logic [ITER_BITS-1:0] count_q, count_d;

    always_comb begin
        valid_d      = valid_q;
        tag_d        = tag_q;
        count_d      = count_q;
        load_ready_o = !valid_q || res_ready_i;
        if (load_valid_i && load_ready_o) begin
            valid_d = 1'b1;
            tag_d   = load_tag_i;
            count_d = load_count_i;
        end else if (res_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            count_q <= count_d;
        end
    end

    assign res_valid_o = valid_q;
    assign res_tag_o   = tag_q;
    assign res_count_o = count_q;

endmodule

// File: rtl/solver_dispatch.sv
// rtl/solver_dispatch.sv - loads host job words into solver_control, starts it and returns tagged results
module solver_dispatch
    import solver_pkg::*;
#(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_BITS       = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LIMB_BITS-1:0]       in_data,
    output logic                       wr_real_en,
    output logic                       wr_imag_en,
    output logic [LIMB_INDEX_BITS-1:0] wr_ind,
    output logic [LIMB_BITS-1:0]       c_wr_data,
    output logic                       wr_num_limbs_en,
    output logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
    output logic                       wr_iter_lim_en,
    output logic [ITER_BITS-1:0]       iter_lim_data,
    output logic                       start,
    input  logic                       out_ready,
    input  logic [ITER_BITS-1:0]       iteration_count,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [TAG_BITS-1:0]        res_tag,
    output logic [ITER_BITS-1:0]       res_count,
    output logic                       busy
);

    state_e                     state_q, state_d;
    logic [TAG_BITS-1:0]        tag_q, tag_d;
    logic [LIMB_INDEX_BITS-1:0] nl_q, nl_d;
    logic [LIMB_INDEX_BITS-1:0] cnt_q, cnt_d;
    logic                       run_first_q, run_first_d;
    logic                       wr_real_q, wr_real_d;
    logic                       wr_imag_q, wr_imag_d;
    logic [LIMB_INDEX_BITS-1:0] wr_ind_q, wr_ind_d;
    logic [LIMB_BITS-1:0]       c_data_q, c_data_d;
    logic                       wr_nl_q, wr_nl_d;
    logic [LIMB_INDEX_BITS-1:0] nl_data_q, nl_data_d;
    logic                       wr_iter_q, wr_iter_d;
    logic [ITER_BITS-1:0]       iter_data_q, iter_data_d;
    logic                       start_q, start_d;
    logic                       accept;
    logic                       buf_load;
    logic                       buf_load_ready;

    assign in_ready = (state_q == ST_HDR) || (state_q == ST_LD_RE) || (state_q == ST_LD_IM);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        nl_d        = nl_q;
        cnt_d       = cnt_q;
        run_first_d = 1'b0;
        wr_real_d   = 1'b0;
        wr_imag_d   = 1'b0;
        wr_ind_d    = wr_ind_q;
        c_data_d    = c_data_q;
        wr_nl_d     = 1'b0;
        nl_data_d   = nl_data_q;
        wr_iter_d   = 1'b0;
        iter_data_d = iter_data_q;
        start_d     = 1'b0;
        buf_load    = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (accept) begin
                    tag_d       = in_data[HDR_TAG_LSB +: TAG_BITS];
                    nl_d        = in_data[HDR_NL_LSB +: LIMB_INDEX_BITS];
                    wr_nl_d     = 1'b1;
                    nl_data_d   = in_data[HDR_NL_LSB +: LIMB_INDEX_BITS];
                    wr_iter_d   = 1'b1;
                    iter_data_d = coerce_iter(in_data[HDR_ITER_LSB +: ITER_BITS]);
                    cnt_d       = '0;
                    state_d     = ST_LD_RE;
                end
            end
            ST_LD_RE, ST_LD_IM: begin
                if (accept) begin
                    wr_real_d = (state_q == ST_LD_RE);
                    wr_imag_d = (state_q == ST_LD_IM);
                    wr_ind_d  = cnt_q;
                    c_data_d  = in_data;
                    // Equality test lets num_limbs = 2^N-1 finish without the counter wrapping first.
                    if (cnt_q == nl_q) begin
                        cnt_d   = '0;
                        state_d = (state_q == ST_LD_RE) ? ST_LD_IM : ST_ARM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (!res_valid) begin
                    start_d     = 1'b1;
                    run_first_d = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                // out_ready may still be high from the previous solve during the start cycle.
                if (!run_first_q && out_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                buf_load = 1'b1;
                if (buf_load_ready) begin
                    state_d = ST_HDR;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_HDR;
            tag_q       <= '0;
            nl_q        <= '0;
            cnt_q       <= '0;
            run_first_q <= 1'b0;
            wr_real_q   <= 1'b0;
            wr_imag_q   <= 1'b0;
            wr_ind_q    <= '0;
            c_data_q    <= '0;
            wr_nl_q     <= 1'b0;
            nl_data_q   <= '0;
            wr_iter_q   <= 1'b0;
            iter_data_q <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            nl_q        <= nl_d;
            cnt_q       <= cnt_d;
            run_first_q <= run_first_d;
            wr_real_q   <= wr_real_d;
            wr_imag_q   <= wr_imag_d;
            wr_ind_q    <= wr_ind_d;
            c_data_q    <= c_data_d;
            wr_nl_q     <= wr_nl_d;
            nl_data_q   <= nl_data_d;
            wr_iter_q   <= wr_iter_d;
            iter_data_q <= iter_data_d;
            start_q     <= start_d;
        end
    end

    solver_result_buf u_result_buf (
        .clk_i        (clock),
        .rst_i        (reset),
        .load_valid_i (buf_load),
        .load_ready_o (buf_load_ready),
        .load_tag_i   (tag_q),
        .load_count_i (iteration_count),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_tag_o    (res_tag),
        .res_count_o  (res_count)
    );

    assign wr_real_en      = wr_real_q;
    assign wr_imag_en      = wr_imag_q;
    assign wr_ind          = wr_ind_q;
    assign c_wr_data       = c_data_q;
    assign wr_num_limbs_en = wr_nl_q;
    assign num_limbs_data  = nl_data_q;
    assign wr_iter_lim_en  = wr_iter_q;
    assign iter_lim_data   = iter_data_q;
    assign start           = start_q;
    assign busy            = (state_q != ST_HDR) || res_valid;

endmodule

// File: tb/tb_solver_dispatch.sv
// tb/tb_solver_dispatch.sv - scoreboard bench for solver_dispatch with a behavioural solver model
module tb_solver_dispatch;

    localparam int LIB = 6;
    localparam int LB  = 32;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic [LB-1:0]  in_data = '0;
    logic           out_ready = 1'b1;
    logic [15:0]    iteration_count = 16'h0;
    logic           res_ready = 1'b1;

    logic           in_ready, wr_real_en, wr_imag_en, wr_num_limbs_en, wr_iter_lim_en;
    logic [LIB-1:0] wr_ind, num_limbs_data;
    logic [LB-1:0]  c_wr_data;
    logic [15:0]    iter_lim_data, res_count;
    logic           start, res_valid, busy;
    logic [7:0]     res_tag;

    solver_dispatch #(.LIMB_INDEX_BITS(LIB), .LIMB_BITS(LB)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_real_en(wr_real_en), .wr_imag_en(wr_imag_en), .wr_ind(wr_ind), .c_wr_data(c_wr_data),
        .wr_num_limbs_en(wr_num_limbs_en), .num_limbs_data(num_limbs_data),
        .wr_iter_lim_en(wr_iter_lim_en), .iter_lim_data(iter_lim_data), .start(start),
        .out_ready(out_ready), .iteration_count(iteration_count), .res_valid(res_valid),
        .res_ready(res_ready), .res_tag(res_tag), .res_count(res_count), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          kind;  // 0 header, 1 real, 2 imag
        int          ind;
        logic [31:0] data;
        logic [15:0] iter;
    } wr_t;

    typedef struct {
        logic [7:0]  tag;
        logic [15:0] count;
    } res_t;

    wr_t         exp_wr[$];
    res_t        exp_res[$];
    logic [15:0] sol_q[$];

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int start_cnt = 0;
    int start_cycle = 0;
    int last_im_cycle = 0;

    // Solver model: clears out_ready the cycle after start, raises it with the result later.
    int          sol_lat = 4;
    int          sol_cnt = 0;
    logic [15:0] sol_pending = 16'hFFFF;

    always @(posedge clock) begin
        if (start) begin
            out_ready <= 1'b0;
            sol_cnt   <= sol_lat;
            if (sol_q.size() > 0) sol_pending <= sol_q.pop_front();
        end else if (sol_cnt > 0) begin
            sol_cnt <= sol_cnt - 1;
            if (sol_cnt == 1) begin
                out_ready       <= 1'b1;
                iteration_count <= sol_pending;
            end
        end
    end

    wr_t         mw;
    res_t        mr;
    logic        hold_prev = 1'b0;
    logic [7:0]  prev_tag;
    logic [15:0] prev_count;

    always @(negedge clock) begin
        cycle++;
        if (!reset) begin
            if (start) begin
                start_cnt++;
                start_cycle = cycle;
            end
            if (wr_num_limbs_en || wr_iter_lim_en) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL hdr_write unexpected: nl=%0d iter=%0d required none", num_limbs_data, iter_lim_data);
                end else begin
                    mw = exp_wr.pop_front();
                    if (mw.kind !== 0 || wr_num_limbs_en !== 1'b1 || wr_iter_lim_en !== 1'b1 ||
                        num_limbs_data !== LIB'(mw.ind) || iter_lim_data !== mw.iter) begin
                        errors++;
                        $display("FAIL hdr_write: kind=%0d nl_en=%b it_en=%b nl=%0d iter=%0d required kind=%0d nl=%0d iter=%0d",
                                 0, wr_num_limbs_en, wr_iter_lim_en, num_limbs_data, iter_lim_data, mw.kind, mw.ind, mw.iter);
                    end
                end
            end
            if (wr_real_en || wr_imag_en) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL limb_write unexpected: re=%b im=%b ind=%0d data=%h required none", wr_real_en, wr_imag_en, wr_ind, c_wr_data);
                end else begin
                    mw = exp_wr.pop_front();
                    if (wr_real_en !== (mw.kind == 1) || wr_imag_en !== (mw.kind == 2) ||
                        wr_ind !== LIB'(mw.ind) || c_wr_data !== mw.data) begin
                        errors++;
                        $display("FAIL limb_write: re=%b im=%b ind=%0d data=%h required kind=%0d ind=%0d data=%h",
                                 wr_real_en, wr_imag_en, wr_ind, c_wr_data, mw.kind, mw.ind, mw.data);
                    end
                end
                if (wr_imag_en) last_im_cycle = cycle;
            end
            if (hold_prev) begin
                checks++;
                if (res_valid !== 1'b1 || res_tag !== prev_tag || res_count !== prev_count) begin
                    errors++;
                    $display("FAIL res_stable: valid=%b tag=%h count=%0d required valid=1 tag=%h count=%0d",
                             res_valid, res_tag, res_count, prev_tag, prev_count);
                end
            end
            if (res_valid && res_ready) begin
                checks++;
                if (exp_res.size() == 0) begin
                    errors++;
                    $display("FAIL result unexpected: tag=%h count=%0d required none", res_tag, res_count);
                end else begin
                    mr = exp_res.pop_front();
                    if (res_tag !== mr.tag || res_count !== mr.count) begin
                        errors++;
                        $display("FAIL result: tag=%h count=%0d required tag=%h count=%0d", res_tag, res_count, mr.tag, mr.count);
                    end
                end
            end
            hold_prev  = res_valid && !res_ready;
            prev_tag   = res_tag;
            prev_count = res_count;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        int n;
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL send_word timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] make_hdr(input logic [7:0] tag, input logic [15:0] iter, input int nl);
        logic [31:0] h;
        h = '0;
        h[7:0]   = tag;
        h[23:8]  = iter;
        h[29:24] = nl[5:0];
        return h;
    endfunction

    task automatic run_job(input logic [7:0] tag, input logic [15:0] iter, input int nl,
                           input logic [31:0] re_base, input logic [31:0] im_base,
                           input logic [15:0] result, input bit toggle);
        exp_wr.push_back('{kind: 0, ind: nl, data: 32'h0, iter: (iter == 16'd0) ? 16'd1 : iter});
        for (int i = 0; i <= nl; i++) exp_wr.push_back('{kind: 1, ind: i, data: re_base + i, iter: 16'h0});
        for (int i = 0; i <= nl; i++) exp_wr.push_back('{kind: 2, ind: i, data: im_base + i, iter: 16'h0});
        exp_res.push_back('{tag: tag, count: result});
        sol_q.push_back(result);
        send_word(make_hdr(tag, iter, nl));
        for (int i = 0; i <= nl; i++) begin
            send_word(re_base + i);
            if (toggle) tick(1);
        end
        for (int i = 0; i <= nl; i++) begin
            send_word(im_base + i);
            if (toggle) tick(1);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_res.size() != 0 || busy) && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL wait_idle timeout: wr_left=%0d res_left=%0d busy=%b required 0 0 0", exp_wr.size(), exp_res.size(), busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: in_ready=%b busy=%b res_valid=%b start=%b required 1 0 0 0", in_ready, busy, res_valid, start);
        end
        checks++;
        if ({wr_real_en, wr_imag_en, wr_num_limbs_en, wr_iter_lim_en} !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobes: %b required 0000", {wr_real_en, wr_imag_en, wr_num_limbs_en, wr_iter_lim_en});
        end
        checks++;
        if (wr_ind !== '0 || c_wr_data !== '0 || num_limbs_data !== '0 || iter_lim_data !== '0 || res_tag !== '0 || res_count !== '0) begin
            errors++;
            $display("FAIL reset_data: ind=%0d data=%h nl=%0d iter=%0d tag=%h count=%0d required all 0",
                     wr_ind, c_wr_data, num_limbs_data, iter_lim_data, res_tag, res_count);
        end
    endtask

    task automatic test_single_job();
        int s0;
        s0 = start_cnt;
        res_ready = 1'b1;
        run_job(8'h5A, 16'd100, 2, 32'h11, 32'h21, 16'd37, 1'b0);
        wait_idle(500);
        checks++;
        if (start_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL single_start_count: %0d required 1", start_cnt - s0);
        end
        checks++;
        if (start_cycle - last_im_cycle !== 1) begin
            errors++;
            $display("FAIL single_start_latency: %0d required 1", start_cycle - last_im_cycle);
        end
    endtask

    task automatic test_stale_ready();
        int s0;
        s0 = start_cnt;
        sol_lat = 6;
        run_job(8'h3C, 16'd50, 1, 32'h300, 32'h400, 16'd99, 1'b0);
        wait_idle(500);
        sol_lat = 4;
        checks++;
        if (start_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL stale_start_count: %0d required 1", start_cnt - s0);
        end
    endtask

    task automatic test_backpressure();
        int s0;
        int n;
        s0 = start_cnt;
        res_ready = 1'b0;
        run_job(8'hA1, 16'd10, 1, 32'h500, 32'h600, 16'd11, 1'b0);
        n = 0;
        while (!res_valid && n < 200) begin
            tick(1);
            n++;
        end
        run_job(8'hB2, 16'd20, 1, 32'h700, 32'h800, 16'd22, 1'b0);
        tick(10);
        checks++;
        if (start_cnt - s0 !== 1 || start !== 1'b0) begin
            errors++;
            $display("FAIL bp_arm_stall: starts=%0d start=%b required 1 0", start_cnt - s0, start);
        end
        checks++;
        if (res_valid !== 1'b1 || res_tag !== 8'hA1 || res_count !== 16'd11 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: valid=%b tag=%h count=%0d busy=%b in_ready=%b required 1 a1 11 1 0",
                     res_valid, res_tag, res_count, busy, in_ready);
        end
        res_ready = 1'b1;
        tick(1);
        res_ready = 1'b0;
        n = 0;
        while (start_cnt - s0 == 1 && n < 4) begin
            tick(1);
            n++;
        end
        checks++;
        if (start_cnt - s0 !== 2) begin
            errors++;
            $display("FAIL bp_release_start: starts=%0d required 2", start_cnt - s0);
        end
        res_ready = 1'b1;
        wait_idle(500);
    endtask

    task automatic test_iter_zero_max();
        run_job(8'h77, 16'd0, 63, 32'h1000, 32'h2000, 16'd500, 1'b0);
        wait_idle(1000);
    endtask

    task automatic test_toggle();
        run_job(8'h0F, 16'd7, 4, 32'hA0, 32'hB0, 16'd1234, 1'b1);
        wait_idle(500);
    endtask

    task automatic test_reset_midjob();
        exp_wr.push_back('{kind: 0, ind: 5, data: 32'h0, iter: 16'd9});
        exp_wr.push_back('{kind: 1, ind: 0, data: 32'hC0, iter: 16'h0});
        exp_wr.push_back('{kind: 1, ind: 1, data: 32'hC1, iter: 16'h0});
        send_word(make_hdr(8'h44, 16'd9, 5));
        send_word(32'hC0);
        send_word(32'hC1);
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || wr_real_en !== 1'b0 || wr_ind !== '0) begin
            errors++;
            $display("FAIL midreset_state: in_ready=%b busy=%b re=%b ind=%0d required 1 0 0 0", in_ready, busy, wr_real_en, wr_ind);
        end
        checks++;
        if (exp_wr.size() !== 0) begin
            errors++;
            $display("FAIL midreset_partial_writes: left=%0d required 0", exp_wr.size());
        end
        tick(5);
        run_job(8'h99, 16'd20, 2, 32'hD0, 32'hE0, 16'd77, 1'b0);
        wait_idle(500);
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_stale_ready();
        test_backpressure();
        test_iter_zero_max();
        test_toggle();
        test_reset_midjob();
        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: run did not finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
